// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush/forward controller for a 5-stage pipeline. It detects load-use
//   hazards, squashes wrong-path instructions on a taken branch, and freezes
//   the pipe while data memory is busy. A run of not-ready memory cycles that
//   lasts too long parks the controller in HALT until reset. Stall and flush
//   events go to saturating debug counters.
//
// Parameters
//   MEM_TIMEOUT  consecutive not-ready MEM cycles before HALT (0 = never)
//   CNT_W        width of stall_cnt / flush_cnt
//
// Ports
//   clk, reset                    clock; synchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2   sources of the ID instruction and their use
//   ex_rs1/ex_rs2, ex_rd          sources and destination held in ID/EX
//   ex_MemRead                    the ID/EX instruction is a load
//   br_taken                      branch resolved taken in EX
//   mem_rd, mem_RegWrite          EX/MEM destination and write flag
//   wb_rd, wb_RegWrite            MEM/WB destination and write flag
//   mem_req, mem_ready            MEM access present / completing this cycle
//   pc_we..exmem_we               pipeline register load enables
//   ifid/idex/memwb_flush         load a bubble (overrides the matching _we)
//   fwd_a, fwd_b                  00 regfile, 10 EX/MEM, 01 MEM/WB
//   mem_err                       high while halted
//   stall_cnt, flush_cnt          saturating event counters
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Wide enough to hold MEM_TIMEOUT itself so wait_cnt+1 can be compared.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0]   TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_inc, flush_inc;

  logic       memstall;
  logic       loaduse;
  logic [WAIT_W:0] wait_inc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign memstall = mem_req & ~mem_ready;
  assign loaduse  = ex_MemRead & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));
  assign wait_inc = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == ex_rs1)
      fwd_a_raw = 2'b10;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs1)
      fwd_a_raw = 2'b01;
    if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == ex_rs2)
      fwd_b_raw = 2'b10;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs2)
      fwd_b_raw = 2'b01;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_err     = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;

    if (!reset) begin
      // Bubble everything while reset is held so nothing stale propagates.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      state_d     = RUN;
      wait_d      = '0;
    end else if (state_q == HALT) begin
      // Frozen with no bubbles; only reset leaves this state.
      mem_err = 1'b1;
    end else if (memstall) begin
      // Freeze everything upstream of MEM; MEM/WB takes a bubble each cycle.
      memwb_flush = 1'b1;
      stall_inc   = 1'b1;
      if (state_q == MEM_WAIT) begin
        if (MEM_TIMEOUT != 0 && wait_inc == TIMEOUT_V)
          state_d = HALT;
        else if (wait_q != '1)
          wait_d = wait_inc[WAIT_W-1:0];
      end else if (MEM_TIMEOUT == 1) begin
        state_d = HALT;
      end else begin
        state_d = MEM_WAIT;
        wait_d  = WAIT_ONE;
      end
    end else begin
      // Memory done (or idle): a branch frozen in EX is acted on right here.
      state_d = RUN;
      wait_d  = '0;
      if (br_taken) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX, let the load move on.
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        idex_we  = 1'b1;
        exmem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_inc && stall_q != '1)
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_inc && flush_q != '1)
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so that
// timeout and counter saturation are reachable quickly). The driver pushes the
// hand-computed expectation for each cycle into a queue; a monitor pops it on
// the falling edge and compares it against the DUT.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_MemRead, br_taken;
  logic       mem_RegWrite, wb_RegWrite, mem_req, mem_ready;
  logic       pc_we, ifid_we, idex_we, exmem_we;
  logic       ifid_flush, idex_flush, memwb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .br_taken(br_taken),
    .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
    .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush}
  localparam logic [6:0] C_RST  = 7'b0000_111;
  localparam logic [6:0] C_HALT = 7'b0000_000;
  localparam logic [6:0] C_NORM = 7'b1111_000;
  localparam logic [6:0] C_MEM  = 7'b0000_001;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_LU   = 7'b0011_010;

  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic [3:0] fwd;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   summary_done = 1'b0;

  task automatic summary();
    if (!summary_done) begin
      summary_done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    logic [6:0] act_ctl;
    logic [3:0] act_fwd;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush};
        act_fwd = {fwd_a, fwd_b};
        n_cmp += 5;
        if (act_ctl !== e.ctl) begin
          n_bad++;
          $display("FAIL %s ctl: got %b expected %b", e.name, act_ctl, e.ctl);
        end
        if (act_fwd !== e.fwd) begin
          n_bad++;
          $display("FAIL %s fwd: got %b expected %b", e.name, act_fwd, e.fwd);
        end
        if (mem_err !== e.err) begin
          n_bad++;
          $display("FAIL %s mem_err: got %b expected %b", e.name, mem_err, e.err);
        end
        if ($isunknown(stall_cnt) || int'(stall_cnt) != e.stall) begin
          n_bad++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.stall);
        end
        if ($isunknown(flush_cnt) || int'(flush_cnt) != e.flush) begin
          n_bad++;
          $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.flush);
        end
        $display("chk %-14s ctl=%b fwd=%b err=%b stall=%0d flush=%0d",
                 e.name, act_ctl, act_fwd, mem_err, stall_cnt, flush_cnt);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  task automatic idle();
    reset = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_MemRead = 1'b0;
    br_taken = 1'b0;
    mem_rd = 5'd0; mem_RegWrite = 1'b0; wb_rd = 5'd0; wb_RegWrite = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_MemRead = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
  endtask

  // Queue the expectation for the current input set, then advance one cycle.
  task automatic cycle(input string nm, input logic [6:0] c, input logic [3:0] f,
                       input logic e, input int s, input int fl);
    exp_t x;
    x.name = nm; x.ctl = c; x.fwd = f; x.err = e; x.stall = s; x.flush = fl;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    idle(); reset = 1'b0;            cycle("reset",       C_RST,  4'b0000, 1'b0, 0, 0);
    idle();                          cycle("idle",        C_NORM, 4'b0000, 1'b0, 0, 0);

    // Load-use: exactly one bubble, then normal flow
    idle(); set_lu(5'd5);            cycle("loaduse_rs1", C_LU,   4'b0000, 1'b0, 0, 0);
    idle();                          cycle("after_bubble",C_NORM, 4'b0000, 1'b0, 1, 0);
    idle(); set_lu(5'd0);            cycle("x0_no_stall", C_NORM, 4'b0000, 1'b0, 1, 0);
    idle(); set_lu(5'd5); id_use_rs1 = 1'b0; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
                                     cycle("unused_src",  C_NORM, 4'b0000, 1'b0, 1, 0);
    idle(); ex_MemRead = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
                                     cycle("loaduse_rs2", C_LU,   4'b0000, 1'b0, 1, 0);

    // Branch together with load-use: branch wins, no stall
    br_taken = 1'b1;                 cycle("br_over_lu",  C_BR,   4'b0000, 1'b0, 2, 0);
    idle();                          cycle("after_br",    C_NORM, 4'b0000, 1'b0, 2, 1);

    // Forwarding
    idle(); ex_rs1 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_RegWrite = 1'b1; wb_RegWrite = 1'b1;
                                     cycle("fwd_mem",     C_NORM, 4'b1000, 1'b0, 2, 1);
    mem_RegWrite = 1'b0;             cycle("fwd_wb",      C_NORM, 4'b0100, 1'b0, 2, 1);
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_RegWrite = 1'b1;
                                     cycle("fwd_x0",      C_NORM, 4'b0000, 1'b0, 2, 1);
    ex_rs1 = 5'd3; ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd3;
                                     cycle("fwd_b_mem",   C_NORM, 4'b0110, 1'b0, 2, 1);

    // Memory wait with a branch frozen in EX; acted on when memory completes
    idle(); br_taken = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 3; i++)      cycle("mem_wait",    C_MEM,  4'b0000, 1'b0, 2 + i, 1);
    mem_ready = 1'b1;                cycle("mem_done_br", C_BR,   4'b0000, 1'b0, 5, 1);
    idle();                          cycle("after_wait",  C_NORM, 4'b0000, 1'b0, 5, 2);

    // Timeout: four frozen cycles, HALT from the fifth, sticky until reset
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 4; i++)      cycle("pre_timeout", C_MEM,  4'b0000, 1'b0, 5 + i, 2);
                                     cycle("halt",        C_HALT, 4'b0000, 1'b1, 9, 2);
    set_lu(5'd3); br_taken = 1'b1; mem_ready = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3; mem_RegWrite = 1'b1;
                                     cycle("halt_sticky", C_HALT, 4'b1000, 1'b1, 9, 2);
    reset = 1'b0;                    cycle("halt_reset",  C_RST,  4'b0000, 1'b0, 9, 2);
    idle();                          cycle("post_reset",  C_NORM, 4'b0000, 1'b0, 0, 0);

    // Reset during MEM_WAIT: back to RUN with wait count cleared
    idle(); mem_req = 1'b1;
    for (int i = 0; i < 2; i++)      cycle("wait_pre_rst",C_MEM,  4'b0000, 1'b0, i, 0);
    reset = 1'b0;                    cycle("wait_reset",  C_RST,  4'b0000, 1'b0, 2, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)      cycle("wait_restart",C_MEM,  4'b0000, 1'b0, i, 0);
                                     cycle("halt_again",  C_HALT, 4'b0000, 1'b1, 4, 0);
    idle(); reset = 1'b0;            cycle("reset2",      C_RST,  4'b0000, 1'b0, 4, 0);

    // Counter saturation at all-ones (CNT_W=4 -> 15)
    idle(); set_lu(5'd12);
    for (int i = 0; i < 17; i++)     cycle("stall_sat",   C_LU,   4'b0000, 1'b0, (i < 15) ? i : 15, 0);
    idle(); br_taken = 1'b1;
    for (int i = 0; i < 17; i++)     cycle("flush_sat",   C_BR,   4'b0000, 1'b0, 15, (i < 15) ? i : 15);
    idle();                          cycle("sat_hold",    C_NORM, 4'b0000, 1'b0, 15, 15);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    summary();
    $finish;
  end

endmodule
